// File: rtl/tt_fifo_pkg.sv
// Shared constants and helpers for the tt_sync_fifo slice.
// Default geometry plus a constant-foldable clog2.
package tt_fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tt_sync_fifo_if.sv
// Push/pop/status bundle of the tile FIFO.
// FIFO_ERR_FLAGS_EN adds the sticky ovf_err/udf_err lines.
interface tt_sync_fifo_if
  import tt_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
);

  localparam int AW = clog2(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
`ifdef FIFO_ERR_FLAGS_EN
  logic             ovf_err;
  logic             udf_err;
`endif

  modport master (
    output wr_en, wr_data, rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    input  ovf_err, udf_err,
`endif
    input  rd_data, rd_valid, full, empty, count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    output ovf_err, udf_err,
`endif
    output rd_data, rd_valid, full, empty, count
  );

endinterface

// File: rtl/tt_fifo_mem.sv
// DEPTH x WIDTH register file: sync write, async read.
// Contents are intentionally not reset.
module tt_fifo_mem
  import tt_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // storage write
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tt_sync_fifo.sv
// Single-clock FIFO with registered read port and ena gating.
// Optional: FIFO_ERR_FLAGS_EN enables sticky ovf_err/udf_err.
module tt_sync_fifo
  import tt_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  tt_sync_fifo_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             push, pop, mem_we;

  tt_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // push/pop qualification and next-state
  always_comb begin
    pop        = bus.rd_en & ~empty_q;
    push       = bus.wr_en & (~full_q | pop);
    mem_we     = push & ena;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (ena) begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        rd_data_d = mem_rdata;
      end
      rd_valid_d = pop;
      count_d    = count_q + {{AW{1'b0}}, push}
                           - {{AW{1'b0}}, pop};
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  // control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_err_q, ovf_err_d;
  logic udf_err_q, udf_err_d;

  // sticky error flags, cleared only by reset
  always_comb begin
    ovf_err_d = ovf_err_q;
    udf_err_d = udf_err_q;
    if (ena) begin
      ovf_err_d = ovf_err_q
                | (bus.wr_en & full_q & ~bus.rd_en);
      udf_err_d = udf_err_q | (bus.rd_en & empty_q);
    end
  end

  // error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  assign bus.ovf_err = ovf_err_q;
  assign bus.udf_err = udf_err_q;
`endif

endmodule

// File: tb/tb_tt_sync_fifo.sv
// Directed bench for tt_sync_fifo (WIDTH=8, DEPTH=16).
// Vector table plus hand sequences and a queue scoreboard.
module tb_tt_sync_fifo;
  import tt_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  int   tests = 0;
  int   failed = 0;

  tt_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) bus ();

  tt_sync_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       rv;
    logic [7:0] rdat;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w,
                       input logic [7:0] d, input logic r);
    ena         = e;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [17:0] pack_out();
    return {bus.rd_valid, bus.rd_data, bus.count,
            bus.full, bus.empty, 2'b00};
  endfunction

  logic [7:0] sb [$];
  logic       m_rv;
  logic [7:0] m_rd;
  logic [17:0] prev;

  initial begin
    vt[0] = '{1, 1, 8'h5C, 1, 0, 8'h00, 5'd1, 0, 0};
    vt[1] = '{1, 0, 8'h00, 1, 1, 8'h5C, 5'd0, 0, 1};
    vt[2] = '{1, 0, 8'h00, 1, 0, 8'h5C, 5'd0, 0, 1};
    vt[3] = '{1, 1, 8'h11, 0, 0, 8'h5C, 5'd1, 0, 0};
    vt[4] = '{0, 1, 8'h22, 1, 0, 8'h5C, 5'd1, 0, 0};
    vt[5] = '{1, 1, 8'h22, 1, 1, 8'h11, 5'd1, 0, 0};
    vt[6] = '{0, 0, 8'h00, 1, 1, 8'h11, 5'd1, 0, 0};
    vt[7] = '{1, 0, 8'h00, 1, 1, 8'h22, 5'd0, 0, 1};
    vt[8] = '{1, 0, 8'h00, 0, 0, 8'h22, 5'd0, 0, 1};

    do_reset();
    chk("rst_state", 32'(pack_out()),
        32'({1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 2'b00}));

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].ena, vt[i].wr, vt[i].wd, vt[i].rd);
      step();
      chk($sformatf("vec%0d", i), 32'(pack_out()),
          32'({vt[i].rv, vt[i].rdat, vt[i].cnt,
               vt[i].full, vt[i].empty, 2'b00}));
    end

    // async reset mid-cycle
    drive(1'b1, 1'b1, 8'h33, 1'b0);
    step();
    step();
    drive(1'b1, 1'b1, 8'h44, 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(pack_out()),
        32'({1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 2'b00}));
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #3;
    rst_n = 1'b1;
    @(negedge clk);

    // fill and drain
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 8'(i + 1), 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_cnt", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      step();
      chk($sformatf("drain%0d", i),
          32'({bus.rd_valid, bus.rd_data}),
          32'({1'b1, 8'(i + 1)}));
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    step();
    chk("drain_end", 32'({bus.rd_valid, bus.empty,
        bus.count}), 32'({1'b0, 1'b1, 5'd0}));

    // full boundary
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 8'(i + 1), 1'b0);
      step();
    end
    drive(1'b1, 1'b1, 8'hAA, 1'b0);
    step();
    chk("full_drop", 32'({bus.rd_valid, bus.full,
        bus.count}), 32'({1'b0, 1'b1, 5'd16}));
    drive(1'b1, 1'b1, 8'h77, 1'b1);
    step();
    chk("full_rw", 32'({bus.rd_valid, bus.rd_data,
        bus.count}), 32'({1'b1, 8'h01, 5'd16}));
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      step();
      chk($sformatf("full_order%0d", i), 32'(bus.rd_data),
          (i < 15) ? 32'(i + 2) : 32'h77);
    end
    chk("full_empty", 32'(bus.empty), 32'd1);

    // interleaved traffic with ena toggling
    do_reset();
    sb.delete();
    m_rv = 1'b0;
    m_rd = 8'h00;
    for (int i = 0; i < 40; i++) begin
      logic e, w, r, p, q;
      logic [7:0] d;
      e = ((i / 3) % 2) == 0;
      w = (i % 3) != 1;
      r = (i % 5) != 0 && i > 2;
      d = 8'(i * 7 + 3);
      prev = pack_out();
      drive(e, w, d, r);
      if (e) begin
        p = r && sb.size() != 0;
        q = w && (sb.size() < 16 || p);
        m_rv = p;
        if (p) m_rd = sb.pop_front();
        if (q) sb.push_back(d);
      end
      step();
      if (!e)
        chk($sformatf("hold%0d", i), 32'(pack_out()),
            32'(prev));
      chk($sformatf("wrap%0d", i), 32'(pack_out()),
          32'({m_rv, m_rd, 5'(sb.size()),
               sb.size() == 16, sb.size() == 0, 2'b00}));
    end

`ifdef FIFO_ERR_FLAGS_EN
    do_reset();
    chk("err_rst", 32'({bus.ovf_err, bus.udf_err}), 32'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    step();
    chk("udf_set", 32'({bus.ovf_err, bus.udf_err}), 32'b01);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 8'(i), 1'b0);
      step();
    end
    chk("ovf_pre", 32'(bus.ovf_err), 32'd0);
    drive(1'b1, 1'b1, 8'hEE, 1'b0);
    step();
    chk("ovf_set", 32'({bus.ovf_err, bus.udf_err}), 32'b11);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    step();
    step();
    chk("err_sticky", 32'({bus.ovf_err, bus.udf_err}),
        32'b11);
    do_reset();
    chk("err_clr", 32'({bus.ovf_err, bus.udf_err}), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
